reg_read_port: RTL and testbench

REG_READ_PORT -- requirements
Module: reg_read_port

---
 rtl/reg_read_port.sv | 139 +++++++++++++
 tb/tb_reg_read_port.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_port.sv
// Single read port onto a 16-entry register bank: one-hot select,
// registered capture, held result until the consumer acknowledges.
module reg_read_port #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [15:0]  rd_sel,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [N-1:0] in4,
    input  logic [N-1:0] in5,
    input  logic [N-1:0] in6,
    input  logic [N-1:0] in7,
    input  logic [N-1:0] in8,
    input  logic [N-1:0] in9,
    input  logic [N-1:0] in10,
    input  logic [N-1:0] in11,
    input  logic [N-1:0] in12,
    input  logic [N-1:0] in13,
    input  logic [N-1:0] in14,
    input  logic [N-1:0] in15,
    input  logic [N-1:0] in16,
    input  logic         rd_ack,
    output logic [N-1:0] rd_data,
    output logic         rd_valid,
    output logic         busy,
    output logic         sel_err,
    output logic [7:0]   rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRIVE,
        ERROR
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [15:0]  sel_q;
    logic         one_hot;
    logic [N-1:0] bank [16];
    logic [N-1:0] picked;

    assign bank[0]  = in1;
    assign bank[1]  = in2;
    assign bank[2]  = in3;
    assign bank[3]  = in4;
    assign bank[4]  = in5;
    assign bank[5]  = in6;
    assign bank[6]  = in7;
    assign bank[7]  = in8;
    assign bank[8]  = in9;
    assign bank[9]  = in10;
    assign bank[10] = in11;
    assign bank[11] = in12;
    assign bank[12] = in13;
    assign bank[13] = in14;
    assign bank[14] = in15;
    assign bank[15] = in16;

    // Zero is excluded explicitly; x & (x-1) clears the lowest set bit.
    assign one_hot = (rd_sel != 16'd0) &&
                     ((rd_sel & (rd_sel - 16'd1)) == 16'd0);

    // AND-OR mux: the latched select is one-hot whenever it is used.
    always_comb begin
        picked = '0;
        for (int k = 0; k < 16; k++) begin
            if (sel_q[k]) begin
                picked = picked | bank[k];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_nxt = one_hot ? CAPTURE : ERROR;
                end
            end
            CAPTURE: state_nxt = DRIVE;
            DRIVE: begin
                if (rd_ack) begin
                    state_nxt = IDLE;
                end
            end
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            sel_err  <= 1'b0;
            rd_count <= '0;
        end else begin
            sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        sel_q   <= rd_sel;
                        sel_err <= !one_hot;
                    end
                end
                CAPTURE: begin
                    rd_data  <= picked;
                    rd_valid <= 1'b1;
                end
                DRIVE: begin
                    if (rd_ack) begin
                        rd_valid <= 1'b0;
                        rd_count <= rd_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_read_port.sv
// Directed bench for reg_read_port with a queue-based scoreboard that
// checks every completed read and every select rejection.
module tb_reg_read_port;

    logic        clk;
    logic        reset;
    logic        rd_req;
    logic [15:0] rd_sel;
    logic        rd_ack;
    logic [31:0] regs [16];
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        sel_err;
    logic [7:0]  rd_count;

    typedef struct {
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   applied = 0;
    int   errs    = 0;

    reg_read_port #(.N(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .in1      (regs[0]),
        .in2      (regs[1]),
        .in3      (regs[2]),
        .in4      (regs[3]),
        .in5      (regs[4]),
        .in6      (regs[5]),
        .in7      (regs[6]),
        .in8      (regs[7]),
        .in9      (regs[8]),
        .in10     (regs[9]),
        .in11     (regs[10]),
        .in12     (regs[11]),
        .in13     (regs[12]),
        .in14     (regs[13]),
        .in15     (regs[14]),
        .in16     (regs[15]),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .sel_err  (sel_err),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read of regs[k] with rd_ack already high: IDLE, CAPTURE, DRIVE.
    task automatic do_read(input int k);
        logic [15:0] s;
        s = '0;
        s[k] = 1'b1;
        exp_q.push_back('{err: 1'b0, data: regs[k]});
        rd_sel = s;
        rd_req = 1'b1;
        rd_ack = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        rd_ack = 1'b0;
    endtask

    // Scoreboard monitor: outputs are sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rd_valid && rd_ack) begin
            applied++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL sb_read: unexpected read data %h", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (e.err || rd_data !== e.data) begin
                    errs++;
                    $display("FAIL sb_read: got %h (err_exp=%0d) expected %h",
                             rd_data, e.err, e.data);
                end
            end
        end
        if (!reset && sel_err) begin
            applied++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL sb_err: unexpected sel_err");
            end else begin
                e = exp_q.pop_front();
                if (!e.err) begin
                    errs++;
                    $display("FAIL sb_err: got sel_err expected read %h",
                             e.data);
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        rd_req = 1'b0;
        rd_sel = '0;
        rd_ack = 1'b0;
        for (int k = 0; k < 16; k++) begin
            regs[k] = 32'h1000_0000 + 32'(k);
        end
        tick();
        tick();
        reset = 1'b0;

        check("rst_data", rd_data, 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(sel_err), 32'h0);
        check("rst_count", 32'(rd_count), 32'h0);

        // Basic read of in5 with ack held high.
        regs[4] = 32'hDEAD_BEEF;
        exp_q.push_back('{err: 1'b0, data: 32'hDEAD_BEEF});
        rd_sel = 16'h0010;
        rd_req = 1'b1;
        rd_ack = 1'b1;
        tick();
        rd_req = 1'b0;
        check("cap_busy", 32'(busy), 32'h1);
        check("cap_valid", 32'(rd_valid), 32'h0);
        tick();
        check("drv_valid", 32'(rd_valid), 32'h1);
        check("drv_data", rd_data, 32'hDEAD_BEEF);
        tick();
        check("done_valid", 32'(rd_valid), 32'h0);
        check("done_busy", 32'(busy), 32'h0);
        check("done_count", 32'(rd_count), 32'h1);
        rd_ack = 1'b0;

        // Rejected selects: two bits set, then none.
        for (int i = 0; i < 2; i++) begin
            rd_sel = (i == 0) ? 16'h0011 : 16'h0000;
            exp_q.push_back('{err: 1'b1, data: 32'h0});
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
            check("err_pulse", 32'(sel_err), 32'h1);
            check("err_valid", 32'(rd_valid), 32'h0);
            check("err_busy", 32'(busy), 32'h1);
            tick();
            check("err_clear", 32'(sel_err), 32'h0);
            check("err_idle", 32'(busy), 32'h0);
            check("err_data", rd_data, 32'hDEAD_BEEF);
            check("err_count", 32'(rd_count), 32'h1);
        end

        // Hold in DRIVE while in16 toggles and rd_req pulses.
        regs[15] = 32'hA5A5_A5A5;
        exp_q.push_back('{err: 1'b0, data: 32'hA5A5_A5A5});
        rd_sel = 16'h8000;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            regs[15] = ~regs[15];
            rd_req = i[0];
            rd_sel = 16'h0001;
            tick();
            check("hold_valid", 32'(rd_valid), 32'h1);
            check("hold_data", rd_data, 32'hA5A5_A5A5);
            check("hold_busy", 32'(busy), 32'h1);
        end
        rd_req = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("hold_done", 32'(busy), 32'h0);
        check("hold_count", 32'(rd_count), 32'h2);
        tick();
        check("no_queue", 32'(busy), 32'h0);

        // Ack outside DRIVE is ignored.
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("idle_ack_cnt", 32'(rd_count), 32'h2);
        check("idle_ack_busy", 32'(busy), 32'h0);
        exp_q.push_back('{err: 1'b0, data: 32'h1000_0002});
        rd_sel = 16'h0004;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("cap_ack_cnt", 32'(rd_count), 32'h2);
        check("cap_ack_valid", 32'(rd_valid), 32'h1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("cap_ack_done", 32'(rd_count), 32'h3);

        // Reach a count of 7, then reset in the middle of a read.
        for (int i = 0; i < 4; i++) begin
            do_read(i + 6);
        end
        rd_sel = 16'h0100;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        check("pre_rst_valid", 32'(rd_valid), 32'h1);
        check("pre_rst_count", 32'(rd_count), 32'h7);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(rd_valid), 32'h0);
        check("mid_rst_data", rd_data, 32'h0);
        check("mid_rst_count", 32'(rd_count), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_valid", 32'(rd_valid), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        // 257 back-to-back reads wrap the counter to 1.
        for (int i = 0; i < 257; i++) begin
            do_read(i % 16);
        end
        check("wrap_count", 32'(rd_count), 32'h1);
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
